// File: rtl/l2cache_control.sv
// L2 cache controller: hit/miss handling, dirty writeback, line allocate.
// Drives datapath array enables and keeps saturating hit/miss counters.
module l2cache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        hit_0,
    input  logic        hit_1,
    input  logic        dirty_0,
    input  logic        dirty_1,
    input  logic        lru,
    input  logic        pmem_resp,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic        pmem_addr_sel,
    output logic        load_valid,
    output logic        load_tag,
    output logic        load_data,
    output logic        load_dirty,
    output logic        dirty_in,
    output logic        data_sel,
    output logic        way_sel,
    output logic        load_lru,
    output logic        lru_in,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CHECK     = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       miss_pending;
    logic       req;
    logic       is_hit;
    logic       hit_way;
    logic       victim_dirty;
    logic       check_hit;
    logic       check_miss;

    assign req          = mem_read | mem_write;
    assign is_hit       = hit_0 | hit_1;
    // way 0 wins when both ways report a hit
    assign hit_way      = ~hit_0;
    assign victim_dirty = lru ? dirty_1 : dirty_0;
    assign check_hit    = (state == CHECK) && req && is_hit;
    assign check_miss   = (state == CHECK) && req && !is_hit;

    // Next-state and combinational array/memory controls
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        load_valid    = 1'b0;
        load_tag      = 1'b0;
        load_data     = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        data_sel      = 1'b0;
        way_sel       = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        case (state)
            IDLE: begin
                if (req)
                    next_state = CHECK;
            end
            CHECK: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (is_hit) begin
                    mem_resp   = 1'b1;
                    load_lru   = 1'b1;
                    lru_in     = ~hit_way;
                    next_state = IDLE;
                    // a write hit merges L1 data and marks the line dirty
                    if (mem_write) begin
                        load_data  = 1'b1;
                        data_sel   = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                        way_sel    = hit_way;
                    end
                end else begin
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp)
                    next_state = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    load_dirty = 1'b1;
                    way_sel    = lru;
                    next_state = CHECK;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Miss tracking so the refill-completion hit is not counted as a hit
    always_ff @(posedge clk) begin
        if (rst)
            miss_pending <= 1'b0;
        else if (check_miss)
            miss_pending <= 1'b1;
        else if (mem_resp)
            miss_pending <= 1'b0;
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (check_hit && !miss_pending && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (check_miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_l2cache_control.sv
// Directed bench for l2cache_control: vector table for single requests,
// hand sequences for fills, writebacks, reset abort and saturation.
module tb_l2cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic        hit_0, hit_1, dirty_0, dirty_1, lru;
    logic        pmem_resp;
    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
    logic        load_valid, load_tag, load_data, load_dirty, dirty_in;
    logic        data_sel, way_sel, load_lru, lru_in;
    logic [15:0] hit_count, miss_count;

    int n_vec  = 0;
    int n_fail = 0;

    l2cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .hit_0(hit_0), .hit_1(hit_1),
        .dirty_0(dirty_0), .dirty_1(dirty_1), .lru(lru),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .load_valid(load_valid),
        .load_tag(load_tag), .load_data(load_data),
        .load_dirty(load_dirty), .dirty_in(dirty_in),
        .data_sel(data_sel), .way_sel(way_sel),
        .load_lru(load_lru), .lru_in(lru_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // bus order: mr pr pw as lv lt ld ldy di ds ws ll li
    function automatic logic [12:0] obus();
        return {mem_resp, pmem_read, pmem_write, pmem_addr_sel,
                load_valid, load_tag, load_data, load_dirty,
                dirty_in, data_sel, way_sel, load_lru, lru_in};
    endfunction

    typedef struct {
        string       name;
        logic [6:0]  in;
        logic [12:0] chk;
        logic [12:0] nxt;
        logic [15:0] hits;
        logic [15:0] misses;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        {mem_read, mem_write, hit_0, hit_1, dirty_0, dirty_1, lru} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // in = {rd, wr, h0, h1, d0, d1, lru}
        vecs[0]  = '{"rd_hit1",   7'b1001000, 13'b1000000000010, 13'b0, 16'd1, 16'd0};
        vecs[1]  = '{"rd_hit0",   7'b1010000, 13'b1000000000011, 13'b0, 16'd1, 16'd0};
        vecs[2]  = '{"rd_hitboth",7'b1011001, 13'b1000000000011, 13'b0, 16'd1, 16'd0};
        vecs[3]  = '{"wr_hit0",   7'b0110000, 13'b1000001111011, 13'b0, 16'd1, 16'd0};
        vecs[4]  = '{"wr_hit1",   7'b0101000, 13'b1000001111110, 13'b0, 16'd1, 16'd0};
        vecs[5]  = '{"rdwr_hit1", 7'b1101000, 13'b1000001111110, 13'b0, 16'd1, 16'd0};
        vecs[6]  = '{"miss_clean1",7'b1000101,13'b0, 13'b0100000000000, 16'd0, 16'd1};
        vecs[7]  = '{"miss_dirty0",7'b1000100,13'b0, 13'b0011000000000, 16'd0, 16'd1};
        vecs[8]  = '{"wmiss_dirty1",7'b0100011,13'b0,13'b0011000000000, 16'd0, 16'd1};
        vecs[9]  = '{"miss_clean0",7'b1000010,13'b0, 13'b0100000000000, 16'd0, 16'd1};
        vecs[10] = '{"no_req",    7'b0010000, 13'b0, 13'b0, 16'd0, 16'd0};

        rst = 1'b0;
        pmem_resp = 1'b0;
        set_in(7'b0);
        tick();
        do_reset();
        check("reset_outs", 32'(obus()), 32'h0);
        check("reset_cnt", {hit_count, miss_count}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            set_in(7'b0);
            pmem_resp = 1'b0;
            do_reset();
            set_in(vecs[i].in);
            tick();
            check({vecs[i].name, "_chk"}, 32'(obus()), 32'(vecs[i].chk));
            tick();
            check({vecs[i].name, "_nxt"}, 32'(obus()), 32'(vecs[i].nxt));
            check({vecs[i].name, "_cnt"}, {hit_count, miss_count},
                  {vecs[i].hits, vecs[i].misses});
        end

        // request dropped while in CHECK
        set_in(7'b0);
        do_reset();
        set_in(7'b1000000);
        tick();
        set_in(7'b0010000);
        #1;
        check("drop_chk", 32'(obus()), 32'h0);
        tick();
        set_in(7'b1010000);
        #1;
        check("drop_idle", 32'(obus()), 32'h0);
        tick();
        check("drop_rehit", 32'(obus()), 32'(13'b1000000000011));
        check("drop_cnt", {hit_count, miss_count}, 32'h0);

        // clean read miss, lru=1, fill takes 5 cycles
        set_in(7'b0);
        do_reset();
        set_in(7'b1000001);
        tick();
        check("cm_chk", 32'(obus()), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            pmem_resp = (i == 4);
            #1;
            if (i == 4)
                check("cm_fill", 32'(obus()), 32'(13'b0100111100100));
            else
                check($sformatf("cm_alloc%0d", i), 32'(obus()),
                      32'(13'b0100000000000));
            tick();
        end
        pmem_resp = 1'b0;
        set_in(7'b1001001);
        #1;
        check("cm_hit", 32'(obus()), 32'(13'b1000000000010));
        tick();
        check("cm_cnt", {hit_count, miss_count}, {16'd0, 16'd1});
        tick();
        tick();
        check("cm_cnt2", {hit_count, miss_count}, {16'd1, 16'd1});

        // dirty miss, lru=0: writeback 3 cycles then fill 2 cycles
        set_in(7'b0);
        do_reset();
        set_in(7'b1000100);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            pmem_resp = (i == 2);
            mem_read  = (i != 1);
            #1;
            check($sformatf("dm_wb%0d", i), 32'(obus()),
                  32'(13'b0011000000000));
            tick();
        end
        pmem_resp = 1'b0;
        mem_read  = 1'b1;
        #1;
        check("dm_alloc", 32'(obus()), 32'(13'b0100000000000));
        tick();
        pmem_resp = 1'b1;
        #1;
        check("dm_fill", 32'(obus()), 32'(13'b0100111100000));
        tick();
        pmem_resp = 1'b0;
        set_in(7'b1010100);
        #1;
        check("dm_hit", 32'(obus()), 32'(13'b1000000000011));
        tick();
        check("dm_cnt", {hit_count, miss_count}, {16'd0, 16'd1});

        // reset during ALLOCATE, then a stray pmem_resp
        set_in(7'b0);
        do_reset();
        set_in(7'b1000000);
        tick();
        tick();
        check("ra_alloc", 32'(obus()), 32'(13'b0100000000000));
        do_reset();
        #1;
        check("ra_after", 32'(obus()), 32'h0);
        set_in(7'b0);
        pmem_resp = 1'b1;
        #1;
        check("ra_stray", 32'(obus()), 32'h0);
        tick();
        pmem_resp = 1'b0;
        set_in(7'b1010000);
        #1;
        check("ra_idle", 32'(obus()), 32'h0);
        check("ra_cnt", {hit_count, miss_count}, 32'h0);

        // hit counter saturation
        set_in(7'b0);
        do_reset();
        set_in(7'b1010000);
        for (int i = 0; i < 65534; i++) begin
            tick();
            tick();
        end
        check("sat_fffe", 32'(hit_count), 32'h0000FFFE);
        tick();
        tick();
        check("sat_ffff", 32'(hit_count), 32'h0000FFFF);
        tick();
        tick();
        check("sat_hold", {hit_count, miss_count}, {16'hFFFF, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
